// File: rtl/uart_irq_ctrl_if.sv
// uart_irq_ctrl_if: event, CSR and interrupt signals between the UART core, the CSR block and uart_irq_ctrl.
interface uart_irq_ctrl_if #(
  parameter int EVENTS_NUM = 32,
  parameter int CNT_W      = 8,
  parameter int TMR_W      = 16,
  parameter int ID_W       = ($clog2(EVENTS_NUM) > 1) ? $clog2(EVENTS_NUM) : 1
);
  logic [EVENTS_NUM-1:0] i_events_enable;
  logic [EVENTS_NUM-1:0] i_events_mask;
  logic [EVENTS_NUM-1:0] i_events_edge;
  logic [EVENTS_NUM-1:0] i_events_itself;
  logic [EVENTS_NUM-1:0] i_status_clr;
  logic [CNT_W-1:0]      i_coal_thresh;
  logic [TMR_W-1:0]      i_coal_timeout;
  logic [EVENTS_NUM-1:0] o_events_stats;
  logic [EVENTS_NUM-1:0] o_irq_bus;
  logic                  o_irq;
  logic [ID_W-1:0]       o_irq_id;
  logic                  o_irq_id_vld;
  modport master (
    output i_events_enable, i_events_mask, i_events_edge, i_events_itself, i_status_clr,
    output i_coal_thresh, i_coal_timeout,
    input  o_events_stats, o_irq_bus, o_irq, o_irq_id, o_irq_id_vld
  );
  modport slave (
    input  i_events_enable, i_events_mask, i_events_edge, i_events_itself, i_status_clr,
    input  i_coal_thresh, i_coal_timeout,
    output o_events_stats, o_irq_bus, o_irq, o_irq_id, o_irq_id_vld
  );
endinterface

// File: rtl/uart_irq_ctrl.sv
// uart_irq_ctrl: sticky W1C event status, masked IRQ bus, lowest-index ID and combined o_irq.
// Define UART_IRQ_COALESCE_EN to drive o_irq from the interrupt-coalescing FSM.
module uart_irq_ctrl #(
  parameter int EVENTS_NUM = 32,
  parameter int CNT_W      = 8,
  parameter int TMR_W      = 16,
  parameter int ID_W       = ($clog2(EVENTS_NUM) > 1) ? $clog2(EVENTS_NUM) : 1
) (
  input  logic          i_clk,
  input  logic          i_nrst,
  uart_irq_ctrl_if.slave bus
);
  logic [EVENTS_NUM-1:0] r_evt_q, r_stats, r_bus;
  logic [EVENTS_NUM-1:0] w_hit, w_stats_nxt, w_bus_nxt;
  logic                  r_irq, w_irq_nxt;
  logic [ID_W-1:0]       w_id;
  // Edge-mode bits only hit when the input was low last cycle; set beats a same-cycle clear.
  assign w_hit       = bus.i_events_enable & bus.i_events_itself & (~bus.i_events_edge | ~r_evt_q);
  assign w_stats_nxt = bus.i_events_enable & (w_hit | (r_stats & ~bus.i_status_clr));
  assign w_bus_nxt   = r_stats & ~bus.i_events_mask;
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_evt_q <= '0;
      r_stats <= '0;
      r_bus   <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_evt_q <= bus.i_events_itself;
      r_stats <= w_stats_nxt;
      r_bus   <= w_bus_nxt;
      r_irq   <= w_irq_nxt;
    end
  end
  always_comb begin
    w_id = '0;
    for (int k = EVENTS_NUM - 1; k >= 0; k--) w_id = r_bus[k] ? ID_W'(k) : w_id;
  end
  assign bus.o_events_stats = r_stats;
  assign bus.o_irq_bus      = r_bus;
  assign bus.o_irq          = r_irq;
  assign bus.o_irq_id       = w_id;
  assign bus.o_irq_id_vld   = |r_bus;
`ifdef UART_IRQ_COALESCE_EN
  localparam int PC_W  = $clog2(EVENTS_NUM + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_ASSERT} state_t;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_sat, w_thr;
  logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
  logic [PC_W-1:0]  w_new;
  logic [SUM_W-1:0] w_sum;
  logic             w_fire, w_bus_empty;
  always_comb begin
    w_new = '0;
    for (int k = 0; k < EVENTS_NUM; k++) w_new = w_new + PC_W'(w_bus_nxt[k] & ~r_bus[k]);
  end
  // IDLE restarts the count from zero; COLLECT accumulates on top of it.
  assign w_sum       = SUM_W'((r_state == S_COLLECT) ? r_cnt : CNT_W'(0)) + SUM_W'(w_new);
  assign w_cnt_sat   = (w_sum > CNT_MAX) ? '1 : w_sum[CNT_W-1:0];
  assign w_thr       = (bus.i_coal_thresh == '0) ? CNT_W'(1) : bus.i_coal_thresh;
  assign w_bus_empty = (r_bus == '0);
  assign w_fire      = (r_cnt >= w_thr) ||
                       ((bus.i_coal_timeout != '0) && (r_tmr >= bus.i_coal_timeout - TMR_W'(1)));
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tmr_nxt   = r_tmr;
    if (r_state == S_IDLE) begin
      w_state_nxt = (w_new != '0) ? S_COLLECT : S_IDLE;
      w_cnt_nxt   = w_cnt_sat;
      w_tmr_nxt   = '0;
    end else if (r_state == S_COLLECT) begin
      w_state_nxt = w_bus_empty ? S_IDLE : (w_fire ? S_ASSERT : S_COLLECT);
      w_cnt_nxt   = w_cnt_sat;
      w_tmr_nxt   = (r_tmr == '1) ? r_tmr : r_tmr + TMR_W'(1);
    end else begin
      w_state_nxt = w_bus_empty ? S_IDLE : S_ASSERT;
      w_cnt_nxt   = w_bus_empty ? '0 : r_cnt;
      w_tmr_nxt   = w_bus_empty ? '0 : r_tmr;
    end
  end
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end
  assign w_irq_nxt = (r_state == S_ASSERT);
`else
  logic w_unused;
  assign w_unused  = ^{bus.i_coal_thresh, bus.i_coal_timeout};
  assign w_irq_nxt = |w_bus_nxt;
`endif
endmodule
